// File: rtl/regfile_wr_arbiter_if.sv
// Writeback bus between the two writeback sources, the arbiter and the regfile port.
// The master side is the upstream pipeline plus hazard unit; the slave side is the arbiter.
interface regfile_wr_arbiter_if #(
    parameter int WIDTH   = 32,
    parameter int REGBITS = 5
);
    logic               a_valid;
    logic               a_ready;
    logic [REGBITS-1:0] a_addr;
    logic [WIDTH-1:0]   a_data;
    logic               b_valid;
    logic               b_ready;
    logic [REGBITS-1:0] b_addr;
    logic [WIDTH-1:0]   b_data;
    logic               regwrite;
    logic [REGBITS-1:0] wa;
    logic [WIDTH-1:0]   wd;
    logic [REGBITS-1:0] ra1;
    logic [REGBITS-1:0] ra2;
    logic               hit1;
    logic               hit2;

    modport master (
        output a_valid, a_addr, a_data, b_valid, b_addr, b_data, ra1, ra2,
        input  a_ready, b_ready, regwrite, wa, wd, hit1, hit2
    );

    modport slave (
        input  a_valid, a_addr, a_data, b_valid, b_addr, b_data, ra1, ra2,
        output a_ready, b_ready, regwrite, wa, wd, hit1, hit2
    );
endinterface

// File: rtl/regfile_wr_arbiter.sv
// Round-robin arbiter sharing one regfile write port between ALU (A) and load (B) writeback,
// with a 1-entry slot per source and pending-write hit flags for the hazard unit.
module regfile_wr_arbiter #(
    parameter int WIDTH   = 32,
    parameter int REGBITS = 5
) (
    input  logic                 clk,
    input  logic                 reset,
    regfile_wr_arbiter_if.slave  bus
);
    localparam int NPORT = 2;
    localparam int NRD   = 2;

    typedef struct packed {
        logic [REGBITS-1:0] addr;
        logic [WIDTH-1:0]   data;
    } wr_req_t;

    wr_req_t [NPORT-1:0]            req;
    wr_req_t [NPORT-1:0]            slot;
    logic    [NPORT-1:0]            req_valid;
    logic    [NPORT-1:0]            slot_full;
    logic    [NPORT-1:0]            grant;
    logic    [NPORT-1:0]            ready;
    logic    [NPORT-1:0]            load;
    logic                           last_grant;  // 0 = A, 1 = B
    logic                           regwrite_q;
    logic    [REGBITS-1:0]          wa_q;
    logic    [WIDTH-1:0]            wd_q;
    logic    [NRD-1:0][REGBITS-1:0] ra;
    logic    [NRD-1:0]              hit;

    assign req_valid = {bus.b_valid, bus.a_valid};
    assign req[0]    = {bus.a_addr, bus.a_data};
    assign req[1]    = {bus.b_addr, bus.b_data};

    // On a tie the port that did not win last time goes; a lone full slot always goes.
    assign grant[0] = slot_full[0] && (!slot_full[1] || last_grant);
    assign grant[1] = slot_full[1] && (!slot_full[0] || !last_grant);

    genvar i;
    generate
        for (i = 0; i < NPORT; i++) begin : g_slot
            // A slot being drained this edge can take a new request at the same time.
            assign ready[i] = !slot_full[i] || grant[i];
            // Writes to r0 complete the handshake but are dropped here.
            assign load[i]  = req_valid[i] && ready[i] && (req[i].addr != '0);

            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    slot_full[i] <= 1'b0;
                    slot[i]      <= '0;
                end else if (load[i]) begin
                    slot_full[i] <= 1'b1;
                    slot[i]      <= req[i];
                end else if (grant[i]) begin
                    slot_full[i] <= 1'b0;
                end
            end
        end
    endgenerate

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            regwrite_q <= 1'b0;
            wa_q       <= '0;
            wd_q       <= '0;
            last_grant <= 1'b1;
        end else if (grant[0]) begin
            regwrite_q   <= 1'b1;
            {wa_q, wd_q} <= slot[0];
            last_grant   <= 1'b0;
        end else if (grant[1]) begin
            regwrite_q   <= 1'b1;
            {wa_q, wd_q} <= slot[1];
            last_grant   <= 1'b1;
        end else begin
            regwrite_q <= 1'b0;
        end
    end

    assign ra = {bus.ra2, bus.ra1};

    generate
        for (i = 0; i < NRD; i++) begin : g_hit
            assign hit[i] = (ra[i] != '0) &&
                            ((slot_full[0] && slot[0].addr == ra[i]) ||
                             (slot_full[1] && slot[1].addr == ra[i]) ||
                             (regwrite_q   && wa_q         == ra[i]));
        end
    endgenerate

    assign bus.a_ready  = ready[0];
    assign bus.b_ready  = ready[1];
    assign bus.regwrite = regwrite_q;
    assign bus.wa       = wa_q;
    assign bus.wd       = wd_q;
    assign bus.hit1     = hit[0];
    assign bus.hit2     = hit[1];
endmodule

// File: tb/tb_regfile_wr_arbiter.sv
// Randomized and directed check of regfile_wr_arbiter against a transaction-level model;
// expected writes go into a scoreboard queue that a separate monitor drains.
module tb_regfile_wr_arbiter;
    localparam int W = 32;
    localparam int R = 5;

    typedef struct {
        logic [R-1:0] addr;
        logic [W-1:0] data;
    } wr_t;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    regfile_wr_arbiter_if #(.WIDTH(W), .REGBITS(R)) bus ();
    regfile_wr_arbiter #(.WIDTH(W), .REGBITS(R)) dut (.clk(clk), .reset(reset), .bus(bus));

    int n_cmp = 0;
    int n_bad = 0;

    // Model: each source owns at most one pending write; the write port carries one per cycle.
    wr_t          exp_q[$];
    bit           m_full[2];
    wr_t          m_slot[2];
    int           m_last;
    bit           m_rw;
    logic [R-1:0] m_wa;
    logic [W-1:0] rf[32];
    bit           acc[2];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    function automatic int winner();
        if (m_full[0] && m_full[1]) return (m_last == 0) ? 1 : 0;
        if (m_full[0]) return 0;
        if (m_full[1]) return 1;
        return -1;
    endfunction

    function automatic bit m_hit(input logic [R-1:0] ra);
        if (ra == 0) return 1'b0;
        for (int p = 0; p < 2; p++)
            if (m_full[p] && m_slot[p].addr == ra) return 1'b1;
        return m_rw && (m_wa == ra);
    endfunction

    // Monitor: every regfile write must be the next one the model predicted.
    always @(negedge clk) begin
        if (!reset && bus.regwrite === 1'b1) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_write: got wa=%0d wd=%0h expected no write", bus.wa, bus.wd);
            end else begin
                wr_t e;
                e = exp_q.pop_front();
                chk("write_addr", bus.wa, e.addr);
                chk("write_data", bus.wd, e.data);
            end
            chk("write_to_r0", bus.wa == 0, 1'b0);
            rf[bus.wa] = bus.wd;
        end
    end

    task automatic drive(input bit av, input logic [R-1:0] aa, input logic [W-1:0] ad,
                         input bit bv, input logic [R-1:0] ba, input logic [W-1:0] bd);
        bus.a_valid = av; bus.a_addr = aa; bus.a_data = ad;
        bus.b_valid = bv; bus.b_addr = ba; bus.b_data = bd;
    endtask

    // Check combinational outputs against the model, then advance one edge (inputs held).
    task automatic cycle();
        int  w;
        bit  rdy[2];
        bit  fire[2];
        wr_t rq[2];
        w = winner();
        for (int p = 0; p < 2; p++) rdy[p] = !m_full[p] || (w == p);
        #1;
        chk("a_ready", bus.a_ready, rdy[0]);
        chk("b_ready", bus.b_ready, rdy[1]);
        chk("regwrite", bus.regwrite, m_rw);
        chk("hit1", bus.hit1, m_hit(bus.ra1));
        chk("hit2", bus.hit2, m_hit(bus.ra2));
        fire[0] = bus.a_valid && rdy[0];
        fire[1] = bus.b_valid && rdy[1];
        rq[0] = '{bus.a_addr, bus.a_data};
        rq[1] = '{bus.b_addr, bus.b_data};
        @(posedge clk);
        if (w >= 0) begin
            exp_q.push_back(m_slot[w]);
            m_last    = w;
            m_rw      = 1'b1;
            m_wa      = m_slot[w].addr;
            m_full[w] = 1'b0;
        end else begin
            m_rw = 1'b0;
        end
        for (int p = 0; p < 2; p++) begin
            if (fire[p] && rq[p].addr != 0) begin
                m_full[p] = 1'b1;
                m_slot[p] = rq[p];
            end
            acc[p] = fire[p];
        end
        #1;
    endtask

    task automatic model_reset();
        m_full[0] = 0; m_full[1] = 0;
        m_last = 1; m_rw = 0; m_wa = '0;
        exp_q.delete();
    endtask

    task automatic do_reset();
        drive(0, '0, '0, 0, '0, '0);
        reset = 1'b1;
        model_reset();
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
    endtask

    initial begin
        bus.ra1 = '0; bus.ra2 = '0;
        for (int k = 0; k < 32; k++) rf[k] = '0;
        do_reset();
        chk("reset_regwrite", bus.regwrite, 1'b0);
        chk("reset_wa", bus.wa, 0);
        chk("reset_wd", bus.wd, 0);

        // A alone: single write latency, then back-to-back stream.
        drive(1, 5'd5, 32'hDEADBEEF, 0, '0, '0);
        cycle();
        drive(0, '0, '0, 0, '0, '0);
        cycle();
        chk("lat_regwrite", bus.regwrite, 1'b1);
        chk("lat_wa", bus.wa, 5);
        chk("lat_wd", bus.wd, 32'hDEADBEEF);
        for (int k = 1; k <= 4; k++) begin
            drive(1, 5'(k), 32'hA000 + k, 0, '0, '0);
            cycle();
            chk("stream_a_accept", acc[0], 1'b1);
        end
        drive(0, '0, '0, 0, '0, '0);
        repeat (5) cycle();

        // Both streaming: strict alternation, A first.
        do_reset();
        for (int k = 0; k < 8; k++) begin
            drive(1, 5'd3, 32'h300 + k, 1, 5'd4, 32'h400 + k);
            cycle();
            if (k == 1) chk("first_grant_a", bus.wa, 3);
        end
        drive(0, '0, '0, 0, '0, '0);
        repeat (4) cycle();

        // Write to r0: accepted, never written.
        do_reset();
        drive(1, 5'd0, 32'h1234, 0, '0, '0);
        cycle();
        chk("r0_accept", acc[0], 1'b1);
        drive(0, '0, '0, 0, '0, '0);
        for (int k = 0; k < 3; k++) begin
            cycle();
            chk("r0_no_write", bus.regwrite, 1'b0);
        end

        // Hazard hit tracks the pending write through slot and write stage.
        do_reset();
        bus.ra1 = 5'd7; bus.ra2 = 5'd0;
        drive(0, '0, '0, 1, 5'd7, 32'h77);
        cycle();
        drive(0, '0, '0, 0, '0, '0);
        chk("hit1_slot", bus.hit1, 1'b1);
        chk("hit2_r0", bus.hit2, 1'b0);
        cycle();
        chk("hit1_wstage", bus.hit1, 1'b1);
        chk("hit1_wa", bus.wa, 7);
        cycle();
        chk("hit1_clear", bus.hit1, 1'b0);

        // Same address from both ports: B's value lands last.
        do_reset();
        drive(1, 5'd9, 32'h11, 1, 5'd9, 32'h22);
        cycle();
        drive(0, '0, '0, 0, '0, '0);
        repeat (4) cycle();
        chk("same_addr_final", rf[9], 32'h22);

        // Randomized traffic with requesters holding until accepted.
        do_reset();
        acc[0] = 1; acc[1] = 1;
        for (int k = 0; k < 400; k++) begin
            if (!bus.a_valid || acc[0]) begin
                bus.a_valid = ($urandom_range(3) != 0);
                bus.a_addr  = 5'($urandom_range(7));
                bus.a_data  = $urandom;
            end
            if (!bus.b_valid || acc[1]) begin
                bus.b_valid = ($urandom_range(3) != 0);
                bus.b_addr  = 5'($urandom_range(7));
                bus.b_data  = $urandom;
            end
            bus.ra1 = 5'($urandom_range(7));
            bus.ra2 = 5'($urandom_range(7));
            cycle();
        end

        // Reset mid-stream with A full and a write in flight.
        for (int k = 0; k < 3; k++) begin
            drive(1, 5'(k + 1), 32'hC0 + k, 0, '0, '0);
            cycle();
        end
        bus.ra1 = 5'd3; bus.ra2 = 5'd2;
        chk("pre_reset_regwrite", bus.regwrite, 1'b1);
        #2 reset = 1'b1;
        model_reset();
        drive(0, '0, '0, 0, '0, '0);
        #1;
        chk("mid_reset_regwrite", bus.regwrite, 1'b0);
        @(posedge clk); #1;
        chk("rst_regwrite", bus.regwrite, 1'b0);
        chk("rst_a_ready", bus.a_ready, 1'b1);
        chk("rst_b_ready", bus.b_ready, 1'b1);
        chk("rst_hit1", bus.hit1, 1'b0);
        chk("rst_hit2", bus.hit2, 1'b0);
        reset = 1'b0;
        repeat (3) cycle();

        chk("scoreboard_drained", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
